// File: rtl/kmer_pkg.sv
// rtl/kmer_pkg.sv - shared k-mer widths, hash multiplier and data types
package kmer_pkg;

    localparam int BYTE         = 8;
    localparam int KMER_SIZE    = 16;
    localparam int INDEX_LENGTH = 16;

    localparam logic [31:0] HASH_MULT = 32'h9E3779B1;

    typedef logic [KMER_SIZE*BYTE-1:0] kmer_t;
    typedef logic [INDEX_LENGTH-1:0]   index_t;

endpackage

// File: rtl/hash_fifo.sv
// rtl/hash_fifo.sv - parameterised synchronous FIFO with push/pop/full/empty/count
module hash_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A simultaneous pop frees the slot, so a push into a full queue still lands.
    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CW-1){1'b0}}, wr_ok} - {{(CW-1){1'b0}}, rd_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/kmer_hasher.sv
// rtl/kmer_hasher.sv - 3-stage k-mer hash pipeline feeding a {hash, index} output FIFO
module kmer_hasher
    import kmer_pkg::*;
#(
    parameter int HASH_BITS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [KMER_SIZE*BYTE-1:0] i_kmer,
    input  logic [INDEX_LENGTH-1:0]   i_kmer_index,
    input  logic                      i_kmer_ready,
    input  logic                      i_kmer_done,
    output logic [HASH_BITS-1:0]      o_hash,
    output logic [INDEX_LENGTH-1:0]   o_hash_index,
    output logic                      o_hash_valid,
    input  logic                      i_hash_ready,
    output logic                      o_hash_done,
    output logic                      o_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = HASH_BITS + INDEX_LENGTH;

    logic [31:0]          a1, b1, h2;
    logic [HASH_BITS-1:0] h3;
    index_t               idx1, idx2, idx3;
    logic                 v1, v2, v3;

    logic [DW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    // Stage valids are reset; the data path is not, it is qualified by the valids.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= i_kmer_ready;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        a1   <= i_kmer[31:0] ^ i_kmer[95:64];
        b1   <= i_kmer[63:32] ^ i_kmer[127:96];
        idx1 <= i_kmer_index;
        h2   <= (a1 * HASH_MULT) ^ b1;
        idx2 <= idx1;
        h3   <= HASH_BITS'(h2 ^ (h2 >> 16));
        idx3 <= idx2;
    end

    assign pop = o_hash_valid && i_hash_ready;

    hash_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (v3),
        .wdata ({h3, idx3}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_hash_valid = !fifo_empty;
    assign o_hash       = fifo_empty ? '0 : fifo_rdata[DW-1:INDEX_LENGTH];
    assign o_hash_index = fifo_empty ? '0 : fifo_rdata[INDEX_LENGTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_overflow  <= 1'b0;
            o_hash_done <= 1'b0;
        end else begin
            if (v3 && fifo_full && !pop) o_overflow <= 1'b1;
            o_hash_done <= i_kmer_done && !i_kmer_ready && !v1 && !v2 && !v3
                           && (fifo_count == '0);
        end
    end

endmodule

// File: doc/kmer_hasher.md
Name: kmer_hasher

Overview:
Consumes the k-mer stream from the double-buffer front end. Inputs are a 16-byte k-mer, its index, a one-cycle ready pulse and a done level. The block computes a fixed 3-stage pipelined hash of each k-mer and delivers {hash, index} pairs to the downstream sorter through a small FIFO with valid/ready handshake. The upstream has no backpressure, so the block accepts one k-mer per cycle unconditionally and flags any loss.

Parameters:
BYTE, 8, bits per byte
KMER_SIZE, 16, k-mer width in bytes (hash function defined for 16 only)
INDEX_LENGTH, 16, k-mer index width in bits
HASH_BITS, 16, output hash width (1..32)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
i_kmer  in  KMER_SIZE*BYTE  k-mer; byte 0 = bits[7:0] = newest base
i_kmer_index  in  INDEX_LENGTH  index of i_kmer
i_kmer_ready  in  1  i_kmer/i_kmer_index valid this cycle
i_kmer_done  in  1  level: upstream finished current buffer
o_hash  out  HASH_BITS  hash at FIFO head
o_hash_index  out  INDEX_LENGTH  index at FIFO head
o_hash_valid  out  1  FIFO non-empty
i_hash_ready  in  1  sorter accepts head this cycle
o_hash_done  out  1  all k-mers of buffer delivered
o_overflow  out  1  sticky: a result was dropped

Behaviour:
- One clock (clk); reset asynchronous, active-low (rstn). Reset clears all stage valids, FIFO pointers/count, o_hash_valid=0, o_hash_done=0, o_overflow=0. Data regs need not reset; o_hash/o_hash_index are 0 when FIFO empty after reset.
- Words: w0=i_kmer[31:0], w1=[63:32], w2=[95:64], w3=[127:96].
- S1 (cycle after sample): a=w0^w2, b=w1^w3, index, v1=i_kmer_ready.
- S2: h=(a*32'h9E3779B1)[31:0]^b, index, v2=v1.
- S3: h3=h^(h>>16), v3=v2; hash=h3[HASH_BITS-1:0].
- Pipeline never stalls. Latency: i_kmer_ready high in cycle 0 -> FIFO written at end of cycle 3 -> o_hash_valid high in cycle 4 (FIFO empty case). Throughput: 1 per cycle.
- FIFO: push=v3; pop=o_hash_valid&&i_hash_ready. Head on o_hash/o_hash_index; holds stable while valid && !ready.
- Full and push without pop: result dropped, count unchanged, o_overflow<=1, stays 1 until reset.
- Full with push and pop same cycle: both succeed, count unchanged, no overflow.
- Empty: pop impossible (valid=0); push on empty makes valid next cycle (no bypass).
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- o_hash_done registered: next = i_kmer_done && !i_kmer_ready && !v1 && !v2 && !v3 && count==0. Drops the cycle after i_kmer_done falls. A k-mer arriving while done is high keeps done low until drained.
- Reset mid-operation: in-flight and queued results discarded, no output activity until new input.

Decomposition:
- Shared package kmer_pkg: BYTE, KMER_SIZE, INDEX_LENGTH, HASH_MULT=32'h9E3779B1, typedef kmer_t (KMER_SIZE x BYTE), index_t.
- Sub-module hash_fifo: parameterised sync FIFO (data width, depth) with push/pop/full/empty/count. Used for the output queue and reusable by the sorter.

Test Plan:
- Reset, then single i_kmer=128'h1, index=5, i_hash_ready=1 -> cycle 4 o_hash_valid=1, o_hash=16'hE786, o_hash_index=5, one cycle only.
- i_kmer=0, index=0 -> o_hash=16'h0000 after 4 cycles; 20 back-to-back k-mers (index 0..19), ready=1 -> 20 outputs in order, 1/cycle, o_overflow=0.
- i_hash_ready=0, 6 consecutive k-mers -> FIFO holds 4 (index 0..3), indices 4,5 dropped, o_overflow=1 sticky; then ready=1 -> exactly 0..3 emitted.
- FIFO full, push and pop same cycle (ready=1 while streaming) -> count stays 4, no overflow.
- Last k-mer then i_kmer_done=1, ready=1 -> o_hash_done rises the cycle after the final pop; i_kmer_done=0 -> done falls next cycle.
- Assert rstn=0 mid-stream with 3 in flight -> o_hash_valid=0, o_overflow=0, o_hash_done=0, no stale outputs after release.
